dequantizer: RTL and testbench
==============================

# dequantizer

Streaming INT8 → INT32 dequantizer: the inverse path of the accumulator-to-activation quantizer. It takes packed INT8 activation beats, subtracts a zero point, scales by a fixed-point multiplier and shift, and saturates to INT32 accumulator-domain values. It sits between the activation buffer read port and the residual-add / route-concat datapath, where stored INT8 feature maps must re-enter the INT32 domain. Per-layer scale configuration is latched between frames through a config handshake.

## Interface
- LANES, 8, INT8 lanes per beat
- ACC_W, 32, output lane width (fixed at 32; a parameter only for package consistency)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous assert, active-low reset; deassertion synchronous to clk
- s_data  in  LANES*8  packed signed INT8; lane i = s_data[8i+7:8i]
- s_valid / s_ready  in / out  1  input handshake
- s_last  in  1  last beat of frame
- m_data  out  LANES*ACC_W  packed signed INT32; lane i = m_data[32i+31:32i]
- m_valid / m_ready  out / in  1  output handshake
- m_last  out  1  last beat of frame, aligned with m_data
- cfg_M  in  32  unsigned multiplier
- cfg_n  in  5  right shift, 0–31
- cfg_zp  in  8  signed zero point
- cfg_valid / cfg_ready  in / out  1  config handshake

## Operation
- Active config registers: M, n, zp. Reset values: M=1, n=0, zp=0.
- FSM states:
  - IDLE → BUSY on the first accepted beat.
  - BUSY → DRAIN on an accepted beat with s_last=1.
  - DRAIN → IDLE when the pipeline holds no valid beats.
  - A single-beat frame (s_last on the first beat) goes IDLE → DRAIN.
- Reset state is IDLE.
- cfg_ready = (state==IDLE) && pipeline empty. A config write occurs on cfg_valid && cfg_ready and takes effect from the next accepted beat.
  - cfg_valid while not ready is held off and not lost; the source keeps it asserted.
  - If cfg_valid && cfg_ready coincide with s_valid in IDLE, the config write wins and s_ready=0 that cycle.
- Per-lane arithmetic:
  - Stage 1: d = x − zp, 9-bit signed.
  - Stage 2: p = d × {1'b0,M}, 42-bit signed.
  - Stage 3: r = (p + rnd) >>> n, arithmetic shift. Saturate r to [−2^31, 2^31−1].
- Rounding term rnd = (n>0) ? 2^(n−1) : 0 when rounding is compiled in, else 0 (floor).
- Lanes are independent. Lane order is preserved; beat order is preserved; m_last travels with its beat.

## Timing
- Three-stage pipeline. Latency is 3 cycles from the accepted input beat to m_valid, with no stall.
- Throughput is 1 beat/cycle.
- Global stall: en = !m_valid || m_ready. s_ready = en && !(state==IDLE && cfg_valid && cfg_ready).
- All stages hold when en=0. No beat is dropped or duplicated.
- Valid and last bits advance with en. Data registers may be unreset.
- Reset values:
  - m_valid=0, m_last=0, m_data=0, s_ready=0 during reset.
  - cfg_ready=1 after reset, since state is IDLE and the pipeline is empty.
- Reset mid-frame: all in-flight beats are discarded, m_valid drops immediately (asynchronously), and config returns to reset values.
- m_data/m_last hold stable while m_valid && !m_ready.

## Configuration
- DEQUANT_ROUND_EN defined: round-half-up via rnd = 2^(n−1) for n>0.
- DEQUANT_ROUND_EN undefined: rnd=0, pure arithmetic-shift floor, bit-matching the quantizer's shift convention.
- Latency and interface are identical in both builds.

## Structure
- quant_pkg holds:
  - ACT_W=8 and ACC_W=32
  - typedefs act_t (signed [7:0]), acc_t (signed [31:0]), mult_t (logic [31:0]), shift_t (logic [4:0])
  - quant_cfg_t struct {M, n, zp}
  - dequant_state_t enum {IDLE, BUSY, DRAIN}
- Sub-module dequant_lane: the three-stage arithmetic pipeline for one lane, with an en input. It is instantiated LANES times by generate.
- The top level owns the FSM, config registers, the handshake, and the valid/last pipeline.

## Test plan
- Identity and latency:
  - Stimulus: M=1, n=0, zp=0; lanes 127, −128, 0, −1.
  - Response: outputs 127, −128, 0, −1 exactly 3 cycles after acceptance.
- Zero point:
  - Stimulus: zp=−5, M=2, n=0, x=10.
  - Response: 30.
- Saturation:
  - Stimulus: M=2^30, n=0, x=127.
  - Response: 0x7FFF_FFFF.
  - Stimulus: x=−128.
  - Response: 0x8000_0000.
- Rounding:
  - Stimulus: M=3, n=1, x=1 and x=−1.
  - Response with DEQUANT_ROUND_EN: 2 and −1. Without: 1 and −2.
- Backpressure:
  - Stimulus: 10-beat frame, m_ready low for 5 cycles mid-stream.
  - Response: s_ready low while stalled; all 10 beats in order; m_last only on beat 10.
- Config gating and reset:
  - Stimulus: cfg_valid asserted in BUSY.
  - Response: cfg_ready=0 until the last beat exits, then the write is accepted.
  - Stimulus: rst_n pulsed low mid-frame.
  - Response: m_valid=0 immediately; post-reset identity config produces x unchanged.

Source files
------------

// File: rtl/quant_pkg.sv
// quant_pkg: types and constants shared by the dequantizer datapath.
//   ACT_W / ACC_W  : activation (INT8) and accumulator (INT32) widths
//   act_t, acc_t   : signed lane types
//   mult_t, shift_t: fixed-point scale multiplier and right-shift amount
//   quant_cfg_t    : active scale configuration {M, n, zp}
//   dequant_state_t: frame-tracking FSM states
package quant_pkg;

    localparam int ACT_W = 8;
    localparam int ACC_W = 32;

    typedef logic signed [ACT_W-1:0] act_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [31:0]             mult_t;
    typedef logic [4:0]              shift_t;

    typedef struct packed {
        mult_t  M;
        shift_t n;
        act_t   zp;
    } quant_cfg_t;

    // Identity scaling: y = x.
    localparam quant_cfg_t CFG_RESET = '{M: 32'd1, n: 5'd0, zp: 8'sd0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } dequant_state_t;

endpackage

// File: rtl/dequant_lane.sv
// dequant_lane: three-stage INT8 -> INT32 dequantization pipeline for one lane.
//   clk, rst_n : clock, asynchronous active-low reset (output register only)
//   en         : global advance enable; every stage holds when low
//   x          : signed INT8 input sample
//   cfg        : active scale configuration {M, n, zp}
//   y          : saturated signed INT32 result
// Build option: DEQUANT_ROUND_EN selects round-half-up before the shift;
// otherwise the shift floors, matching the quantizer's convention.
module dequant_lane
    import quant_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  act_t       x,
    input  quant_cfg_t cfg,
    output acc_t       y
);

    logic signed [8:0]  d_reg;
    logic signed [41:0] p_reg;
    acc_t               y_reg;

    logic signed [41:0] d_ext;
    logic signed [41:0] m_ext;
    logic signed [42:0] rnd;
    logic signed [42:0] sum;
    logic signed [42:0] shifted;
    acc_t               y_next;

    always_comb begin
        d_ext = 42'(d_reg);
        // M is unsigned: a zero MSB keeps it positive in the signed product.
        m_ext = $signed({10'b0, cfg.M});
        rnd   = '0;
`ifdef DEQUANT_ROUND_EN
        if (cfg.n != 5'd0) begin
            rnd[6'(cfg.n) - 6'd1] = 1'b1;
        end
`endif
        sum     = $signed({p_reg[41], p_reg}) + rnd;
        shifted = sum >>> cfg.n;
        // In range when the bits above bit 31 are all copies of the sign.
        if (shifted[42:31] == '0 || shifted[42:31] == '1) begin
            y_next = shifted[31:0];
        end else if (shifted[42]) begin
            y_next = 32'sh8000_0000;
        end else begin
            y_next = 32'sh7FFF_FFFF;
        end
    end

    // Stages 1 and 2 carry only data; their validity lives in the top level.
    always_ff @(posedge clk) begin
        if (en) begin
            d_reg <= {x[7], x} - {cfg.zp[7], cfg.zp};
            p_reg <= d_ext * m_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg <= '0;
        end else if (en) begin
            y_reg <= y_next;
        end
    end

    assign y = y_reg;

endmodule

// File: rtl/dequantizer.sv
// dequantizer: streaming INT8 -> INT32 dequantizer, LANES lanes per beat.
//   clk, rst_n            : clock, asynchronous active-low reset
//   s_data/s_valid/s_ready/s_last : packed INT8 input stream
//   m_data/m_valid/m_ready/m_last : packed INT32 output stream (3-cycle latency)
//   cfg_M/cfg_n/cfg_zp/cfg_valid/cfg_ready : per-layer scale config, accepted
//                           only between frames with the pipeline empty
// Build option: DEQUANT_ROUND_EN enables round-half-up in each lane.
module dequantizer #(
    parameter int LANES = 8,
    parameter int ACC_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES*8-1:0]     s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_last,
    output logic [LANES*ACC_W-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    input  logic [31:0]            cfg_M,
    input  logic [4:0]             cfg_n,
    input  logic [7:0]             cfg_zp,
    input  logic                   cfg_valid,
    output logic                   cfg_ready
);
    import quant_pkg::*;

    dequant_state_t state_reg, state_next;
    quant_cfg_t     cfg_reg;
    logic [2:0]     valid_reg;
    logic [2:0]     last_reg;

    logic en;
    logic pipe_empty;
    logic cfg_fire;
    logic s_fire;

    assign en         = !valid_reg[2] || m_ready;
    assign pipe_empty = (valid_reg == 3'b000);

    always_comb begin
        cfg_ready  = rst_n && (state_reg == IDLE) && pipe_empty;
        cfg_fire   = cfg_valid && cfg_ready;
        // A pending config write takes priority over a beat in IDLE.
        s_ready    = rst_n && en && !(state_reg == IDLE && cfg_fire);
        s_fire     = s_valid && s_ready;
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (s_fire) state_next = s_last ? DRAIN : BUSY;
            end
            BUSY: begin
                if (s_fire && s_last) state_next = DRAIN;
            end
            DRAIN: begin
                // A new frame may start while the previous one drains.
                if (s_fire)          state_next = s_last ? DRAIN : BUSY;
                else if (pipe_empty) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cfg_reg   <= CFG_RESET;
            valid_reg <= '0;
            last_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (cfg_fire) begin
                cfg_reg <= '{M: cfg_M, n: cfg_n, zp: $signed(cfg_zp)};
            end
            if (en) begin
                valid_reg <= {valid_reg[1:0], s_fire};
                last_reg  <= {last_reg[1:0], s_fire && s_last};
            end
        end
    end

    assign m_valid = valid_reg[2];
    assign m_last  = last_reg[2];

    // Config only changes with the pipeline empty, so every stage can read
    // the active registers directly without per-beat copies.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            dequant_lane u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .x     (s_data[8*gi +: 8]),
                .cfg   (cfg_reg),
                .y     (m_data[ACC_W*gi +: ACC_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_dequantizer.sv
module tb_dequantizer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_last;
    logic [255:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic [31:0]  cfg_M;
    logic [4:0]   cfg_n;
    logic [7:0]   cfg_zp;
    logic         cfg_valid;
    logic         cfg_ready;

    always #5 clk = ~clk;

    dequantizer #(.LANES(8), .ACC_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .cfg_M     (cfg_M),
        .cfg_n     (cfg_n),
        .cfg_zp    (cfg_zp),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference configuration, updated whenever a config write is observed.
    longint mdl_M  = 1;
    int     mdl_n  = 0;
    int     mdl_zp = 0;

    logic [255:0] exp_data_q[$];
    logic         exp_last_q[$];
    logic [255:0] last_out = '0;
    int           n_out = 0;
    int           n_last_seen = 0;

    logic         mon_en = 1'b0;
    logic         hold_chk = 1'b0;
    logic [255:0] hold_data = '0;
    logic         hold_last = 1'b0;

    logic rand_bp = 1'b0;
    logic rand_ready = 1'b1;
    logic fixed_ready = 1'b1;
    assign m_ready = rand_bp ? rand_ready : fixed_ready;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural model: plain integer arithmetic on each lane.
    function automatic logic [255:0] ref_beat(input logic [63:0] xv);
        logic [255:0] out;
        longint p;
        longint r;
        int x;
        out = '0;
        for (int i = 0; i < 8; i++) begin
            x = int'($signed(xv[8*i +: 8]));
            p = longint'(x - mdl_zp) * mdl_M;
`ifdef DEQUANT_ROUND_EN
            if (mdl_n > 0) p = p + (longint'(1) <<< (mdl_n - 1));
`endif
            r = p >>> mdl_n;
            if (r > 64'sd2147483647)       r = 64'sd2147483647;
            else if (r < -64'sd2147483648) r = -64'sd2147483648;
            out[32*i +: 32] = r[31:0];
        end
        return out;
    endfunction

    function automatic logic [255:0] sext_beat(input logic [63:0] xv);
        logic [255:0] out;
        out = '0;
        for (int i = 0; i < 8; i++) out[32*i +: 32] = {{24{xv[8*i+7]}}, xv[8*i +: 8]};
        return out;
    endfunction

    // Output monitor: scoreboard compare, hold-stability check, one line per beat.
    always @(negedge clk) begin
        if (!mon_en) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check("hold_data", m_data, hold_data);
                check("hold_last", {255'b0, m_last}, {255'b0, hold_last});
            end
            hold_chk  = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
            if (m_valid && m_ready) begin
                if (exp_data_q.size() == 0) begin
                    check("unexpected_beat", {255'b0, m_valid}, 256'd0);
                end else begin
                    logic [255:0] ed;
                    logic el;
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    check("beat_data", m_data, ed);
                    check("beat_last", {255'b0, m_last}, {255'b0, el});
                    last_out = m_data;
                    if (m_last) n_last_seen++;
                    $display("out beat %0d last=%0d data=%h", n_out, m_last, m_data);
                    n_out++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rand_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send_beat(input logic [63:0] data, input logic last);
        int waited;
        waited = 0;
        s_data  = data;
        s_last  = last;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!s_ready) begin
            check("send_timeout", {255'b0, s_ready}, 256'd1);
        end else begin
            exp_data_q.push_back(ref_beat(data));
            exp_last_q.push_back(last);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic write_cfg(input logic [31:0] m, input logic [4:0] n, input logic [7:0] zp);
        int waited;
        waited = 0;
        cfg_M     = m;
        cfg_n     = n;
        cfg_zp    = zp;
        cfg_valid = 1'b1;
        @(negedge clk);
        while (!cfg_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!cfg_ready) begin
            check("cfg_timeout", {255'b0, cfg_ready}, 256'd1);
        end else begin
            check("cfg_gate_empty", {254'b0, m_valid, exp_data_q.size() == 0}, 256'd1);
            mdl_M  = longint'(m);
            mdl_n  = int'(n);
            mdl_zp = int'($signed(zp));
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        @(negedge clk);
        while ((exp_data_q.size() != 0 || m_valid) && waited < 500) begin
            waited++;
            @(negedge clk);
        end
        if (exp_data_q.size() != 0) check("drain_timeout", 256'(exp_data_q.size()), 256'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] x;
        int last0;
        int out0;
        rst_n     = 1'b0;
        s_data    = '0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        cfg_M     = '0;
        cfg_n     = '0;
        cfg_zp    = '0;
        cfg_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_m_valid", {255'b0, m_valid}, 256'd0);
        check("rst_m_last", {255'b0, m_last}, 256'd0);
        check("rst_m_data", m_data, 256'd0);
        check("rst_s_ready", {255'b0, s_ready}, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cfg_ready", {255'b0, cfg_ready}, 256'd1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Identity and 3-cycle latency
        x = 64'hFF00_807F_FF00_807F;
        send_beat(x, 1'b1);
        @(negedge clk);
        check("lat_c1", {255'b0, m_valid}, 256'd0);
        @(negedge clk);
        check("lat_c2", {255'b0, m_valid}, 256'd0);
        @(negedge clk);
        check("lat_c3", {255'b0, m_valid}, 256'd1);
        wait_drain();
        check("ident_l0", {224'b0, last_out[31:0]},   256'h7F);
        check("ident_l1", {224'b0, last_out[63:32]},  256'hFFFF_FF80);
        check("ident_l2", {224'b0, last_out[95:64]},  256'h0);
        check("ident_l3", {224'b0, last_out[127:96]}, 256'hFFFF_FFFF);

        // Zero point
        write_cfg(32'd2, 5'd0, 8'hFB);
        send_beat(64'h0A0A_0A0A_0A0A_0A0A, 1'b1);
        wait_drain();
        check("zp_l0", {224'b0, last_out[31:0]}, 256'd30);

        // Saturation
        write_cfg(32'h4000_0000, 5'd0, 8'h00);
        send_beat(64'h0000_0000_0000_807F, 1'b1);
        wait_drain();
        check("sat_hi", {224'b0, last_out[31:0]},  256'h7FFF_FFFF);
        check("sat_lo", {224'b0, last_out[63:32]}, 256'h8000_0000);

        // Rounding vs floor
        write_cfg(32'd3, 5'd1, 8'h00);
        send_beat(64'h0000_0000_0000_FF01, 1'b1);
        wait_drain();
`ifdef DEQUANT_ROUND_EN
        check("rnd_pos", {224'b0, last_out[31:0]},  256'd2);
        check("rnd_neg", {224'b0, last_out[63:32]}, 256'hFFFF_FFFF);
`else
        check("rnd_pos", {224'b0, last_out[31:0]},  256'd1);
        check("rnd_neg", {224'b0, last_out[63:32]}, 256'hFFFF_FFFE);
`endif

        // Config write and beat presented together in IDLE: config wins
        cfg_M     = 32'd5;
        cfg_n     = 5'd2;
        cfg_zp    = 8'h03;
        cfg_valid = 1'b1;
        x         = {$urandom, $urandom};
        s_data    = x;
        s_last    = 1'b1;
        s_valid   = 1'b1;
        @(negedge clk);
        check("cfg_wins_s_ready", {255'b0, s_ready}, 256'd0);
        check("cfg_wins_cfg_ready", {255'b0, cfg_ready}, 256'd1);
        mdl_M  = 5;
        mdl_n  = 2;
        mdl_zp = 3;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        send_beat(x, 1'b1);
        wait_drain();

        // Backpressure: 10-beat frame, 5-cycle output stall mid-stream
        last0 = n_last_seen;
        out0  = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) send_beat({$urandom, $urandom}, i == 9);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                fixed_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_s_ready", {255'b0, s_ready}, 256'd0);
                end
                @(posedge clk);
                #1;
                fixed_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_beats", 256'(n_out - out0), 256'd10);
        check("bp_lasts", 256'(n_last_seen - last0), 256'd1);

        // Config held off while a frame is in flight
        fork
            begin
                for (int i = 0; i < 4; i++) send_beat({$urandom, $urandom}, i == 3);
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                cfg_valid = 1'b1;
                #1;
                check("cfg_busy", {255'b0, cfg_ready}, 256'd0);
                write_cfg(32'd7, 5'd3, 8'hF0);
            end
        join
        send_beat({$urandom, $urandom}, 1'b1);
        wait_drain();

        // Randomized frames, configs and backpressure
        rand_bp = 1'b1;
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                logic [31:0] rm;
                rm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
                write_cfg(rm, 5'($urandom_range(0, 31)), 8'($urandom));
            end
            for (int b = 0, len = $urandom_range(1, 12); b < len; b++) begin
                send_beat({$urandom, $urandom}, b == len - 1);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_drain();
        rand_bp = 1'b0;

        // Reset mid-frame
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            s_data  = {$urandom, $urandom};
            s_last  = 1'b0;
            s_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        #3;
        check("pre_rst_m_valid", {255'b0, m_valid}, 256'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", {255'b0, m_valid}, 256'd0);
        check("mid_rst_m_data", m_data, 256'd0);
        check("mid_rst_s_ready", {255'b0, s_ready}, 256'd0);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_data_q.delete();
        exp_last_q.delete();
        mdl_M  = 1;
        mdl_n  = 0;
        mdl_zp = 0;
        mon_en = 1'b1;
        @(negedge clk);
        check("post_rst_cfg_ready", {255'b0, cfg_ready}, 256'd1);
        check("post_rst_m_valid", {255'b0, m_valid}, 256'd0);
        @(posedge clk);
        #1;
        x = {$urandom, $urandom};
        send_beat(x, 1'b1);
        wait_drain();
        check("post_rst_identity", last_out, sext_beat(x));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
